// File: rtl/imem_arbiter_if.sv
// Bus bundle between the fetch/debug requesters, the imem_arbiter and the
// instruction memory read port. The slave modport is the arbiter's view.
interface imem_arbiter_if;
    localparam int unsigned ADDR_W = 15;
    localparam int unsigned DATA_W = 48;

    // Port A: instruction fetch
    logic              i_a_req;
    logic [ADDR_W-1:0] i_a_addr;
    logic [DATA_W-1:0] o_a_data;
    logic              o_a_ack;

    // Port B: debug / loader
    logic              i_b_req;
    logic [ADDR_W-1:0] i_b_addr;
    logic [DATA_W-1:0] o_b_data;
    logic              o_b_ack;

    // Memory read port
    logic [ADDR_W-1:0] o_mem_addr;
    logic              o_mem_read;
    logic [DATA_W-1:0] i_mem_data;
    logic              i_mem_done;

    modport slave (
        input  i_a_req, i_a_addr, i_b_req, i_b_addr, i_mem_data, i_mem_done,
        output o_a_data, o_a_ack, o_b_data, o_b_ack, o_mem_addr, o_mem_read
    );

    modport master (
        output i_a_req, i_a_addr, i_b_req, i_b_addr, i_mem_data, i_mem_done,
        input  o_a_data, o_a_ack, o_b_data, o_b_ack, o_mem_addr, o_mem_read
    );
endinterface

// File: rtl/imem_arbiter.sv
// Two-port arbiter/sequencer for the 32K x 48 instruction memory read port.
// Port A (fetch) and port B (debug/loader) share one level-sensitive
// read/done memory. Tie-break: fixed priority to A by default; define
// IMEM_ARB_RR_EN for round-robin (grant the port not granted last).
module imem_arbiter (
    input  logic          clk,
    input  logic          reset_n,
    imem_arbiter_if.slave bus
);
    localparam int unsigned ADDR_W = 15;
    localparam int unsigned DATA_W = 48;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RELEASE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_read_q, mem_read_d;
    logic              owner_b_q, owner_b_d;
    logic [DATA_W-1:0] a_data_q, a_data_d;
    logic [DATA_W-1:0] b_data_q, b_data_d;
    logic              a_ack_q, a_ack_d;
    logic              b_ack_q, b_ack_d;
    logic              grant_c;
    logic              pick_b_c;

`ifdef IMEM_ARB_RR_EN
    logic last_b_q, last_b_d;

    // Round-robin pick: B wins a tie only if A was granted last
    always_comb begin
        pick_b_c = bus.i_b_req & (~bus.i_a_req | ~last_b_q);
    end

    // Pointer follows every grant
    always_comb begin
        last_b_d = last_b_q;
        if (grant_c) begin
            last_b_d = pick_b_c;
        end
    end

    // Pointer register; reset leaves it at "B granted last" so A wins the first tie
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_b_q <= 1'b1;
        end else begin
            last_b_q <= last_b_d;
        end
    end
`else
    // Fixed priority: A always wins a tie
    always_comb begin
        pick_b_c = bus.i_b_req & ~bus.i_a_req;
    end
`endif

    // Next-state and output logic for the read/done sequencer
    always_comb begin
        state_d    = state_q;
        mem_addr_d = mem_addr_q;
        mem_read_d = mem_read_q;
        owner_b_d  = owner_b_q;
        a_data_d   = a_data_q;
        b_data_d   = b_data_q;
        a_ack_d    = 1'b0;
        b_ack_d    = 1'b0;
        grant_c    = 1'b0;

        case (state_q)
            ST_WAIT: begin
                if (bus.i_mem_done) begin
                    if (owner_b_q) begin
                        b_data_d = bus.i_mem_data;
                        b_ack_d  = 1'b1;
                    end else begin
                        a_data_d = bus.i_mem_data;
                        a_ack_d  = 1'b1;
                    end
                    mem_read_d = 1'b0;
                    state_d    = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                // Done must be seen low before a new read; then behave as IDLE
                if (!bus.i_mem_done) begin
                    state_d = ST_IDLE;
                    grant_c = bus.i_a_req | bus.i_b_req;
                end
            end
            default: begin
                grant_c = bus.i_a_req | bus.i_b_req;
            end
        endcase

        if (grant_c) begin
            owner_b_d  = pick_b_c;
            mem_addr_d = pick_b_c ? bus.i_b_addr : bus.i_a_addr;
            mem_read_d = 1'b1;
            state_d    = ST_WAIT;
        end
    end

    // State and output registers; reset parks in RELEASE to ignore a stale done
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_RELEASE;
            mem_addr_q <= '0;
            mem_read_q <= 1'b0;
            owner_b_q  <= 1'b0;
            a_data_q   <= '0;
            b_data_q   <= '0;
            a_ack_q    <= 1'b0;
            b_ack_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_addr_q <= mem_addr_d;
            mem_read_q <= mem_read_d;
            owner_b_q  <= owner_b_d;
            a_data_q   <= a_data_d;
            b_data_q   <= b_data_d;
            a_ack_q    <= a_ack_d;
            b_ack_q    <= b_ack_d;
        end
    end

    assign bus.o_mem_addr = mem_addr_q;
    assign bus.o_mem_read = mem_read_q;
    assign bus.o_a_data   = a_data_q;
    assign bus.o_a_ack    = a_ack_q;
    assign bus.o_b_data   = b_data_q;
    assign bus.o_b_ack    = b_ack_q;

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Two-port arbiter and sequencer for the 32K×48 instruction memory. It shares the single memory read port between the CPU instruction-fetch unit (port A) and the debug/loader read path (port B). It drives the memory's level-sensitive read/done protocol: hold read until done, then drop read until done clears. It returns each word to its requester with a one-cycle acknowledge. Sits between the fetch/debug units and the instruction memory; no write path.

## Interface
- No parameters; widths fixed: address 15 bits, data 48 bits.
- clk  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- i_a_req  in  1  port A (fetch) request; level.
- i_a_addr  in  15  port A word address; sampled at grant only.
- o_a_data  out  48  port A read data; registered, held until the next port A ack.
- o_a_ack  out  1  port A completion; one-cycle pulse, o_a_data valid in the same cycle.
- i_b_req, i_b_addr, o_b_data, o_b_ack: same as port A, for port B (debug/loader).
- o_mem_addr  out  15  memory address; registered at grant.
- o_mem_read  out  1  memory read strobe; level.
- i_mem_data  in  48  memory read data.
- i_mem_done  in  1  memory done; goes high one cycle after read is asserted, stays high while read is held, clears one cycle after read drops.

## Operation
- States: IDLE, WAIT, RELEASE.
- IDLE: if any request is sampled, arbitrate, latch the winner's address into o_mem_addr, record the grant owner, set o_mem_read=1, and go to WAIT. Otherwise stay in IDLE.
- WAIT: hold o_mem_read=1 and o_mem_addr. On sampling i_mem_done=1:
  - capture i_mem_data into the owner's data register;
  - pulse the owner's ack;
  - clear o_mem_read;
  - go to RELEASE.
- RELEASE: wait for i_mem_done=0. When it is sampled low, act exactly as IDLE in the same cycle: grant directly if a request is pending, else go to IDLE.
- A requester holds req and addr until its ack. A req still high in the cycle after its ack is a new request, with the address sampled at that grant. Address changes while waiting are ignored.
- The non-owner's data and ack are never disturbed.
- Arbitration applies only when both requests are sampled in the same cycle. A lone request is always granted.
- Reset (asynchronous, any state, including mid-read) sets:
  - state=RELEASE, so no read issues until i_mem_done is sampled 0; this protects against a stale done from the memory;
  - o_mem_read=0, o_mem_addr=0;
  - o_a_ack=o_b_ack=0, o_a_data=o_b_data=0;
  - round-robin pointer = "last granted B".

## Timing
- Request first sampled at the end of cycle N: o_mem_read high in cycle N+1; i_mem_done high in N+2; ack and data in N+3, with o_mem_read low in N+3.
- i_mem_done is low in N+4. A pending request is granted at the end of N+4, so the next o_mem_read is high in N+5.
- Back-to-back throughput: one word per 4 cycles. Latency from first sampled request to ack: 3 cycles after the sampling edge.
- Losing requester under continuous contention: served at most one access later with round-robin; may starve with fixed priority.
- Ack is never asserted in two consecutive cycles for the same port.
- o_mem_read is never high in the cycle immediately after an ack.

## Configuration
- IMEM_ARB_RR_EN defined: round-robin. On a tie, grant the port not granted last; the pointer updates on every grant.
- IMEM_ARB_RR_EN undefined: fixed priority, A always wins ties; no pointer register.

## Test plan
- Single fetch: reset released with i_mem_done=0; A requests addr 15'h0010 holding mem[0x10]=48'h123456789ABC. Required: o_mem_read high in cycle N+1, o_a_ack pulse with o_a_data=48'h123456789ABC in N+3, o_b_ack stays 0.
- Back-to-back: A holds req, with addr changed to 0x0011 after its first ack. Required: second o_mem_read rises 4 cycles after the first; second ack delivers mem[0x11]; o_mem_read is low in the cycle after each ack.
- Contention: A=0x0001 and B=0x0002 are both held continuously for 4 grants. Required:
  - with IMEM_ARB_RR_EN, acks alternate A,B,A,B;
  - without it, acks are A,A,A,A and B is never acked;
  - o_b_data stays 0 throughout the fixed-priority run.
- Address-change immunity: B requests 0x0100; i_b_addr is changed to 0x0200 in the cycle after grant. Required: o_mem_addr stays 0x0100 and o_b_data equals mem[0x100].
- Reset mid-read: reset_n pulled low in WAIT while i_mem_done=1, then released. Required:
  - immediately on assertion, o_mem_read=0, all acks 0 and both data registers 0;
  - no o_mem_read until i_mem_done has been sampled 0;
  - a pending A request is then served normally.
- Stale-done guard: force i_mem_done=1 for 3 cycles after reset release while A requests. Required: o_mem_read stays 0 until the first cycle after i_mem_done is sampled low.
